// File: rtl/sram_1r1w_banked_sky130.sv
// sram_1r1w_banked_sky130: pseudo-dual-port (1R + 1W per cycle) SRAM assembled from
// 32-bit 1RW macros, tiled in width (banks) and depth (tiles). Accepted writes enter a
// small in-order FIFO whose head drains into any tile the current read leaves idle.
// Optional feature macro: SRAM_WBUF_FWD_EN. When defined, a read that matches buffered
// writes returns the youngest buffered data. When undefined, such a read stalls until
// the matching entry has drained.
module sram_1r1w_banked_sky130 #(
  parameter int unsigned DATA_BIT    = 128,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_BIT    = $clog2(DEPTH),
  parameter int unsigned MACRO_WIDTH = 32,
  parameter int unsigned MACRO_DEPTH = (DEPTH < 512) ? 128 : 512,
  parameter int unsigned WBUF_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid_i,
  output logic                          wr_ready_o,
  input  logic [ADDR_BIT-1:0]           wr_addr_i,
  input  logic [DATA_BIT-1:0]           wr_data_i,
  input  logic                          rd_valid_i,
  output logic                          rd_ready_o,
  input  logic [ADDR_BIT-1:0]           rd_addr_i,
  output logic                          rd_data_valid_o,
  output logic [DATA_BIT-1:0]           rd_data_o,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count_o,
  output logic                          busy_o
);

  localparam int unsigned NUM_BANKS = DATA_BIT / MACRO_WIDTH;
  localparam int unsigned NUM_TILES = DEPTH / MACRO_DEPTH;
  localparam int unsigned LOCAL_BIT = $clog2(MACRO_DEPTH);
  localparam int unsigned TILE_BIT  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned PTR_BIT   = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_BIT   = PTR_BIT + 1;

  // Tile index of a word address; always 0 when a single tile covers the depth.
  function automatic logic [TILE_BIT-1:0] tile_of(input logic [ADDR_BIT-1:0] a);
    return TILE_BIT'(a >> LOCAL_BIT);
  endfunction

  // Word address inside a tile.
  function automatic logic [LOCAL_BIT-1:0] local_of(input logic [ADDR_BIT-1:0] a);
    return LOCAL_BIT'(a);
  endfunction

  // Write buffer storage and pointers.
  logic [ADDR_BIT-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DATA_BIT-1:0] wb_data_q [WBUF_DEPTH];
  logic [PTR_BIT-1:0]  head_q, head_d;
  logic [PTR_BIT-1:0]  tail_q, tail_d;
  logic [CNT_BIT-1:0]  count_q, count_d;

  // Arbitration signals.
  logic                wbuf_full;
  logic                wbuf_empty;
  logic                wbuf_hit;
  logic                starve_block;
  logic                rd_acc;
  logic                wr_acc;
  logic                drain;
  logic [TILE_BIT-1:0] rd_tile;
  logic [TILE_BIT-1:0] head_tile;
  logic [TILE_BIT-1:0] drain_tile;
  logic [ADDR_BIT-1:0] drain_addr;
  logic [DATA_BIT-1:0] drain_data;

  // Per-tile macro controls and read data.
  logic                 mac_csb  [NUM_TILES];
  logic                 mac_web  [NUM_TILES];
  logic [LOCAL_BIT-1:0] mac_addr [NUM_TILES];
  logic [DATA_BIT-1:0]  tile_dout [NUM_TILES];

  // Read pipeline.
  logic                rd_v1_q;
  logic [TILE_BIT-1:0] rd_tile1_q;
  logic                rd_data_valid_q;
  logic [DATA_BIT-1:0] rd_data_q;
  logic [DATA_BIT-1:0] rd_data_d;
  logic [DATA_BIT-1:0] macro_rdata;

`ifdef SRAM_WBUF_FWD_EN
  logic [DATA_BIT-1:0] wbuf_hit_data;
  logic                fwd_hit1_q;
  logic [DATA_BIT-1:0] fwd_data1_q;
`endif

  // Compare the read address with every occupied buffer entry, oldest first so the
  // youngest match wins.
  always_comb begin
    wbuf_hit = 1'b0;
`ifdef SRAM_WBUF_FWD_EN
    wbuf_hit_data = '0;
`endif
    for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
      if ((CNT_BIT'(k) < count_q) && (wb_addr_q[head_q + PTR_BIT'(k)] == rd_addr_i)) begin
        wbuf_hit = 1'b1;
`ifdef SRAM_WBUF_FWD_EN
        wbuf_hit_data = wb_data_q[head_q + PTR_BIT'(k)];
`endif
      end
    end
  end

  // Handshakes, read-priority arbitration and buffer bookkeeping.
  always_comb begin
    wbuf_full    = (count_q == CNT_BIT'(WBUF_DEPTH));
    wbuf_empty   = (count_q == '0);
    rd_tile      = tile_of(rd_addr_i);
    head_tile    = tile_of(wb_addr_q[head_q]);
    // A full buffer whose head is stuck behind reads to the same tile forces a drain.
    starve_block = wbuf_full && (rd_tile == head_tile);
`ifdef SRAM_WBUF_FWD_EN
    rd_ready_o   = !starve_block;
`else
    rd_ready_o   = !(starve_block || wbuf_hit);
`endif
    wr_ready_o   = !wbuf_full;
    rd_acc       = rd_valid_i && rd_ready_o;
    wr_acc       = wr_valid_i && wr_ready_o;
    // An empty buffer lets the incoming write drain in its own acceptance cycle.
    drain_addr   = wbuf_empty ? wr_addr_i : wb_addr_q[head_q];
    drain_data   = wbuf_empty ? wr_data_i : wb_data_q[head_q];
    drain_tile   = tile_of(drain_addr);
    drain        = (!wbuf_empty || wr_acc) && (!rd_acc || (drain_tile != rd_tile));
    head_d       = head_q + PTR_BIT'(drain);
    tail_d       = tail_q + PTR_BIT'(wr_acc);
    count_d      = count_q + CNT_BIT'(wr_acc) - CNT_BIT'(drain);
  end

  // Macro enables: the read owns its tile, the drain takes another, the rest idle.
  always_comb begin
    for (int unsigned t = 0; t < NUM_TILES; t++) begin
      mac_csb[t]  = 1'b1;
      mac_web[t]  = 1'b1;
      mac_addr[t] = local_of(drain_addr);
      if (rd_acc && (rd_tile == TILE_BIT'(t))) begin
        mac_csb[t]  = 1'b0;
        mac_addr[t] = local_of(rd_addr_i);
      end else if (drain && (drain_tile == TILE_BIT'(t))) begin
        mac_csb[t]  = 1'b0;
        mac_web[t]  = 1'b0;
      end
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Buffer payload; entries are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wb_addr_q[tail_q] <= wr_addr_i;
      wb_data_q[tail_q] <= wr_data_i;
    end
  end

  // Macro array: one 1RW 32-bit macro per (tile, bank), registered read data.
  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [MACRO_WIDTH-1:0] mem [MACRO_DEPTH];
      logic [MACRO_WIDTH-1:0] dout_q;

      // Single access per cycle: write when web low, otherwise read into dout.
      always_ff @(posedge clk) begin
        if (!mac_csb[t]) begin
          if (!mac_web[t]) begin
            mem[mac_addr[t]] <= drain_data[b*MACRO_WIDTH +: MACRO_WIDTH];
          end else begin
            dout_q <= mem[mac_addr[t]];
          end
        end
      end

      assign tile_dout[t][b*MACRO_WIDTH +: MACRO_WIDTH] = dout_q;
    end
  end

  // Pick the macro output of the tile read in the previous cycle.
  always_comb begin
    macro_rdata = '0;
    for (int unsigned t = 0; t < NUM_TILES; t++) begin
      if (rd_tile1_q == TILE_BIT'(t)) begin
        macro_rdata = tile_dout[t];
      end
    end
`ifdef SRAM_WBUF_FWD_EN
    rd_data_d = fwd_hit1_q ? fwd_data1_q : macro_rdata;
`else
    rd_data_d = macro_rdata;
`endif
  end

  // Two-stage read pipeline: macro access, then output register that holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q         <= 1'b0;
      rd_tile1_q      <= '0;
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      rd_v1_q         <= rd_acc;
      if (rd_acc) begin
        rd_tile1_q <= rd_tile;
      end
      rd_data_valid_q <= rd_v1_q;
      if (rd_v1_q) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

`ifdef SRAM_WBUF_FWD_EN
  // Capture forwarded write data at read acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit1_q  <= 1'b0;
      fwd_data1_q <= '0;
    end else if (rd_acc) begin
      fwd_hit1_q  <= wbuf_hit;
      fwd_data1_q <= wbuf_hit_data;
    end
  end
`endif

  assign rd_data_valid_o = rd_data_valid_q;
  assign rd_data_o       = rd_data_q;
  assign wbuf_count_o    = count_q;
  assign busy_o          = (count_q != '0) || rd_v1_q || rd_data_valid_q;

endmodule

// File: tb/tb_sram_1r1w_banked_sky130.sv
// Bench for sram_1r1w_banked_sky130 with 4 tiles (DEPTH=512, MACRO_DEPTH=128).
// A queue-and-array model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_sram_1r1w_banked_sky130;

  logic         clk;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [8:0]   wr_addr;
  logic [127:0] wr_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [8:0]   rd_addr;
  logic         rd_data_valid;
  logic [127:0] rd_data;
  logic [2:0]   wbuf_count;
  logic         busy;

  int tests = 0;
  int fails = 0;

  sram_1r1w_banked_sky130 #(
    .DATA_BIT(128), .DEPTH(512), .MACRO_DEPTH(128), .WBUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rd_data_valid_o(rd_data_valid), .rd_data_o(rd_data),
    .wbuf_count_o(wbuf_count), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic int tile(input logic [8:0] a);
    return int'(a) / 128;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { logic [8:0] a; logic [127:0] d; } wr_t;
  logic [127:0] m_mem [int];
  wr_t          m_q [$];
  bit           m_p1_v, m_p1_known, m_out_v, m_out_known;
  logic [127:0] m_p1_d, m_out_d;
  bit           e_rd_ready, e_wr_ready, e_busy, m_rd_acc, m_wr_acc, m_known;
  logic [127:0] m_val;

  // Check all outputs against the model mid-cycle, then advance the model one edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_p1_v = 0; m_p1_known = 1; m_p1_d = '0;
      m_out_v = 0; m_out_known = 1; m_out_d = '0;
    end
    e_wr_ready = (m_q.size() < 4);
    e_rd_ready = 1;
    if (m_q.size() == 4 && tile(rd_addr) == tile(m_q[0].a)) e_rd_ready = 0;
`ifndef SRAM_WBUF_FWD_EN
    foreach (m_q[i]) if (m_q[i].a == rd_addr) e_rd_ready = 0;
`endif
    e_busy = (m_q.size() != 0) || m_p1_v || m_out_v;
    chk("m_wr_ready", 128'(wr_ready), 128'(e_wr_ready));
    chk("m_rd_ready", 128'(rd_ready), 128'(e_rd_ready));
    chk("m_rd_data_valid", 128'(rd_data_valid), 128'(m_out_v));
    chk("m_wbuf_count", 128'(wbuf_count), 128'(m_q.size()));
    chk("m_busy", 128'(busy), 128'(e_busy));
    if (m_out_known) chk("m_rd_data", rd_data, m_out_d);
    if (rst_n) begin
      m_rd_acc = rd_valid && e_rd_ready;
      m_wr_acc = wr_valid && e_wr_ready;
      m_known = 1;
      m_val = '0;
      if (m_mem.exists(int'(rd_addr))) m_val = m_mem[int'(rd_addr)];
      else m_known = 0;
`ifdef SRAM_WBUF_FWD_EN
      foreach (m_q[i]) if (m_q[i].a == rd_addr) begin m_val = m_q[i].d; m_known = 1; end
`endif
      if (m_p1_v) begin m_out_d = m_p1_d; m_out_known = m_p1_known; end
      m_out_v = m_p1_v;
      m_p1_v = m_rd_acc; m_p1_d = m_val; m_p1_known = m_known;
      if (m_wr_acc) m_q.push_back('{a: wr_addr, d: wr_data});
      if (m_q.size() > 0 && (!m_rd_acc || tile(m_q[0].a) != tile(rd_addr))) begin
        m_mem[int'(m_q[0].a)] = m_q[0].d;
        void'(m_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wv, input logic [8:0] wa, input logic [127:0] wd,
                       input bit rv, input logic [8:0] ra);
    wr_valid = wv; wr_addr = wa; wr_data = wd; rd_valid = rv; rd_addr = ra;
    cyc();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 9'd0, '0, 0, 9'd0);
  endtask

  // Hold a read until accepted; returns one cycle after acceptance with inputs idle.
  task automatic hold_read(input logic [8:0] ra);
    bit done = 0;
    wr_valid = 0; rd_valid = 1; rd_addr = ra;
    for (int i = 0; i < 16 && !done; i++) begin
      #1;
      if (rd_ready) done = 1;
      cyc();
    end
    rd_valid = 0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL hold_read: read of %0d not accepted within 16 cycles", ra);
    end
  endtask

  initial begin
    rst_n = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; rd_valid = 0; rd_addr = '0;
    repeat (3) cyc();
    chk("rst_wr_ready", 128'(wr_ready), 128'd1);
    chk("rst_rd_data_valid", 128'(rd_data_valid), 128'd0);
    chk("rst_rd_data", rd_data, 128'd0);
    chk("rst_wbuf_count", 128'(wbuf_count), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    rst_n = 1;
    cyc();

    // 1: basic write then read, 2-cycle latency.
    drive(1, 9'd5, pat(8'hA5), 0, 9'd0);
    idle(2);
    chk("t1_count_idle", 128'(wbuf_count), 128'd0);
    hold_read(9'd5);
    cyc();
    chk("t1_valid", 128'(rd_data_valid), 128'd1);
    chk("t1_data", rd_data, pat(8'hA5));

    // 2: same-cycle write and read of one address returns the old data.
    drive(1, 9'd3, pat(8'h11), 0, 9'd0);
    idle(2);
    drive(1, 9'd3, pat(8'h22), 1, 9'd3);
    wr_valid = 0;
    #1;
`ifdef SRAM_WBUF_FWD_EN
    chk("t2_fwd_ready", 128'(rd_ready), 128'd1);
    cyc();
    rd_valid = 0;
    chk("t2_old_valid", 128'(rd_data_valid), 128'd1);
    chk("t2_old_data", rd_data, pat(8'h11));
    cyc();
    chk("t2_new_valid", 128'(rd_data_valid), 128'd1);
    chk("t2_new_data", rd_data, pat(8'h22));
`else
    chk("t2_stall", 128'(rd_ready), 128'd0);
    cyc();
    chk("t2_old_valid", 128'(rd_data_valid), 128'd1);
    chk("t2_old_data", rd_data, pat(8'h11));
    hold_read(9'd3);
    cyc();
    chk("t2_new_valid", 128'(rd_data_valid), 128'd1);
    chk("t2_new_data", rd_data, pat(8'h22));
`endif
    idle(2);

    // 3: reads to tile 0 and writes to tile 1 both proceed every cycle.
    for (int i = 0; i < 8; i++) drive(1, 9'(i), pat(8'(8'h30 + i)), 0, 9'd0);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_addr = 9'(128 + i); wr_data = pat(8'(8'h40 + i));
      rd_valid = 1; rd_addr = 9'(i);
      #1;
      chk("t3_rd_ready", 128'(rd_ready), 128'd1);
      chk("t3_wr_ready", 128'(wr_ready), 128'd1);
      cyc();
      chk("t3_count_le1", 128'(wbuf_count <= 3'd1), 128'd1);
    end
    idle(3);
    hold_read(9'd130);
    cyc();
    chk("t3_tile1_data", rd_data, pat(8'h42));
    idle(1);

    // 4: fill the buffer with tile-0 writes while reads hold tile 0.
    for (int i = 0; i < 4; i++) drive(1, 9'(10 + i), pat(8'(8'h50 + i)), 1, 9'(i));
    chk("t4_full_count", 128'(wbuf_count), 128'd4);
    wr_valid = 1; wr_addr = 9'd14; wr_data = pat(8'h54); rd_valid = 1; rd_addr = 9'd4;
    #1;
    chk("t4_wr_ready_low", 128'(wr_ready), 128'd0);
    chk("t4_rd_ready_low", 128'(rd_ready), 128'd0);
    cyc();
    chk("t4_count_after_drain", 128'(wbuf_count), 128'd3);
    idle(6);
    chk("t4_drained", 128'(wbuf_count), 128'd0);
    hold_read(9'd12);
    cyc();
    chk("t4_data", rd_data, pat(8'h52));
    idle(1);

    // 5: two buffered writes to one address; the read sees the younger one.
    drive(1, 9'd7, pat(8'h01), 1, 9'd0);
    drive(1, 9'd7, pat(8'h02), 1, 9'd1);
    chk("t5_buffered", 128'(wbuf_count), 128'd2);
    hold_read(9'd7);
    cyc();
    chk("t5_valid", 128'(rd_data_valid), 128'd1);
    chk("t5_data", rd_data, pat(8'h02));
    idle(6);

    // 6: reset with buffered writes and reads in flight.
    for (int i = 0; i < 3; i++) drive(1, 9'(20 + i), pat(8'(8'h60 + i)), 0, 9'd0);
    idle(2);
    for (int i = 0; i < 3; i++) drive(1, 9'(20 + i), pat(8'(8'hE0 + i)), 1, 9'(i));
    chk("t6_pre_count", 128'(wbuf_count), 128'd3);
    chk("t6_pre_valid", 128'(rd_data_valid), 128'd1);
    wr_valid = 0; rd_valid = 0;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", 128'(rd_data_valid), 128'd0);
    chk("t6_rst_count", 128'(wbuf_count), 128'd0);
    chk("t6_rst_busy", 128'(busy), 128'd0);
    cyc();
    rst_n = 1;
    cyc();
    hold_read(9'd20);
    cyc();
    chk("t6_data20", rd_data, pat(8'h60));
    hold_read(9'd22);
    cyc();
    chk("t6_data22", rd_data, pat(8'h62));
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
